// File: rtl/seq_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_framer_pkg
// Description : Shared types for the sequence framer: scalar/byte aliases and
//               the framer FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_framer_pkg;

  typedef logic       ulogic1;
  typedef logic [7:0] ulogic8;

  typedef enum logic [2:0] {
    FILL      = 3'd0,
    DISCARD   = 3'd1,
    DRAIN     = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } framer_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_framer_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_framer_if
// Description : Bundles the producer handshake, the burst output toward the
//               tracker, the tracker's done pulse and the status outputs.
//               master = environment side, slave = framer side.
//   in_valid/in_data/in_last/in_ready : valid/ready byte stream from producer
//   start/inputA                      : replayed burst, one byte per cycle
//   done                              : completion pulse from the tracker
//   seq_len/overflow                  : status of the last captured sequence
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_framer_if #(
  parameter int DEPTH = 16
) ();
  import seq_framer_pkg::*;

  ulogic1                 in_valid;
  ulogic1                 in_ready;
  ulogic8                 in_data;
  ulogic1                 in_last;
  ulogic1                 start;
  ulogic8                 inputA;
  ulogic1                 done;
  logic [$clog2(DEPTH):0] seq_len;
  ulogic1                 overflow;

  modport master (
    output in_valid, in_data, in_last, done,
    input  in_ready, start, inputA, seq_len, overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, done,
    output in_ready, start, inputA, seq_len, overflow
  );

endinterface
`default_nettype wire

// File: rtl/seq_buffer.sv
`default_nettype none
// ============================================================================
// Module      : seq_buffer
// Description : DEPTH x 8 register file, one synchronous write port and one
//               registered read port. Storage is not reset; only the read
//               register is, because it drives the burst byte directly.
//   clk, rst_n          : clock, asynchronous active-low reset (read reg only)
//   i_wr_en/addr/data   : synchronous write port
//   i_rd_en/i_rd_addr   : load read register from storage
//   i_rd_clr            : force read register to zero (has priority)
//   o_rd_data           : registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module seq_buffer
  import seq_framer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire ulogic1                   i_wr_en,
  input  wire logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  wire ulogic8                   i_wr_data,
  input  wire ulogic1                   i_rd_en,
  input  wire ulogic1                   i_rd_clr,
  input  wire logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output wire ulogic8                   o_rd_data
);

  ulogic8 r_mem [DEPTH];
  ulogic8 r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= 8'h00;
    end else if (i_rd_clr) begin
      r_rd_data <= 8'h00;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/seq_framer.sv
`default_nettype none
// ============================================================================
// Module      : seq_framer
// Description : Captures one byte sequence from a valid/ready producer,
//               replays it as a gap-free start/inputA burst, then waits for
//               the tracker's done pulse plus GAP_CYCLES idle cycles before
//               accepting the next sequence. Sequences longer than DEPTH are
//               truncated and flag a sticky overflow.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : seq_framer_if.slave (in_valid/in_ready/in_data/in_last,
//             start/inputA, done, seq_len, overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_framer
  import seq_framer_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 2
) (
  input wire logic    clk,
  input wire logic    reset_n,
  seq_framer_if.slave bus
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = 1;
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = DEPTH - 1;
  localparam logic [c_PTR_W:0]   c_LEN_ONE  = 1;
  localparam logic [c_PTR_W:0]   c_LEN_FULL = DEPTH;
  localparam logic [c_GAP_W-1:0] c_GAP_ONE  = 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = GAP_CYCLES - 1;

  framer_state_t      r_state;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_GAP_W-1:0] r_gap_cnt;
  logic [c_PTR_W:0]   r_seq_len;
  ulogic1             r_in_ready;
  ulogic1             r_start;
  ulogic1             r_overflow;
  ulogic1             r_drain_end;   // last byte already issued this burst

  ulogic1 w_beat;
  ulogic1 w_wr_en;
  ulogic1 w_rd_en;
  ulogic1 w_rd_clr;
  ulogic8 w_rd_data;

  assign w_beat   = bus.in_valid & r_in_ready;
  assign w_wr_en  = w_beat & (r_state == FILL);
  // The buffer's read register is the inputA register: loading it issues a
  // byte, clearing it ends the burst in the same edge that drops start.
  assign w_rd_en  = (r_state == DRAIN) & ~r_drain_end;
  assign w_rd_clr = (r_state == DRAIN) &  r_drain_end;

  seq_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.in_data),
    .i_rd_en   (w_rd_en),
    .i_rd_clr  (w_rd_clr),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= FILL;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_gap_cnt   <= '0;
      r_seq_len   <= '0;
      r_in_ready  <= 1'b0;
      r_start     <= 1'b0;
      r_overflow  <= 1'b0;
      r_drain_end <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          r_in_ready <= 1'b1;
          if (w_beat) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (bus.in_last) begin
              r_seq_len  <= {1'b0, r_wr_ptr} + c_LEN_ONE;
              r_state    <= DRAIN;
              r_in_ready <= 1'b0;
            end else if (r_wr_ptr == c_PTR_LAST) begin
              // Buffer full without a last byte: keep the first DEPTH bytes
              // and swallow the rest of the sequence.
              r_overflow <= 1'b1;
              r_seq_len  <= c_LEN_FULL;
              r_state    <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (w_beat && bus.in_last) begin
            r_state    <= DRAIN;
            r_in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          r_in_ready <= 1'b0;
          if (!r_drain_end) begin
            r_start  <= 1'b1;
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if ({1'b0, r_rd_ptr} == (r_seq_len - c_LEN_ONE)) begin
              r_drain_end <= 1'b1;
            end
          end else begin
            r_start     <= 1'b0;
            r_drain_end <= 1'b0;
            r_state     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.done) begin
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end
        end
        GAP: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_in_ready <= 1'b1;
            r_state    <= FILL;
          end else begin
            r_gap_cnt <= r_gap_cnt + c_GAP_ONE;
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.start    = r_start;
  assign bus.inputA   = w_rd_data;
  assign bus.seq_len  = r_seq_len;
  assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seq_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_framer
// Description : Self-checking bench for seq_framer. The reference model is a
//               byte queue: the expected burst is the first min(n, DEPTH)
//               pushed bytes, starting one cycle after the in_last beat, and
//               overflow is sticky once any sequence exceeds DEPTH bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_framer;

  localparam int DEPTH = 16;
  localparam int GAP   = 2;
  localparam int W_MAX = 64;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  seq_framer_if #(.DEPTH(DEPTH)) bus ();

  seq_framer #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  bit         exp_ovf     = 1'b0;
  logic       samp_start[W_MAX];
  logic [7:0] samp_a[W_MAX];
  logic       samp_rdy[W_MAX];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what the burst and status should be for tx_q.
  task automatic model_seq();
    exp_q.delete();
    for (int i = 0; i < tx_q.size() && i < DEPTH; i++) exp_q.push_back(tx_q[i]);
    if (tx_q.size() > DEPTH) exp_ovf = 1'b1;
  endtask

  // Expected {start, inputA} k cycles after the in_last beat.
  function automatic logic [8:0] exp_sample(input int k);
    if (k >= 1 && k <= exp_q.size()) return {1'b1, exp_q[k-1]};
    return 9'h000;
  endfunction

  // Push tx_q with random idle cycles (garbage data while not valid).
  task automatic push_seq(input int gap_pct);
    for (int i = 0; i < tx_q.size(); i++) begin
      int guard;
      bit got;
      while ($urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_last  = 1'($urandom);
        step();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = tx_q[i];
      bus.in_last  = (i == tx_q.size() - 1);
      guard = 0;
      got   = 1'b0;
      while (!got) begin
        logic rdy;
        rdy = bus.in_ready;
        step();
        if (rdy === 1'b1) got = 1'b1;
        else begin
          guard++;
          if (guard > 100) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout byte %0d: in_ready=%b, required 1", i, bus.in_ready);
            got = 1'b1;
          end
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  // Sample outputs for n cycles starting right after the in_last beat;
  // optionally raise done during sample done_at (seen on the next edge).
  task automatic observe(input int n, input int done_at);
    for (int k = 0; k < n; k++) begin
      samp_start[k] = bus.start;
      samp_a[k]     = bus.inputA;
      samp_rdy[k]   = bus.in_ready;
      bus.done      = (k == done_at);
      step();
    end
    bus.done = 1'b0;
  endtask

  task automatic finish_seq();
    int guard;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    guard = 0;
    while (bus.in_ready !== 1'b1) begin
      step();
      guard++;
      if (guard > 20) begin
        vectors++;
        miscompares++;
        $display("FAIL refill_timeout: in_ready=%b, required 1", bus.in_ready);
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if ({bus.start, bus.inputA, bus.in_ready, bus.seq_len, bus.overflow} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: start=%b inputA=%0d in_ready=%b seq_len=%0d overflow=%b, required all 0",
                 c, bus.start, bus.inputA, bus.in_ready, bus.seq_len, bus.overflow);
      end
      step();
    end
    #3 reset_n = 1'b1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL release_ready_early: in_ready=%b, required 0", bus.in_ready);
    end
    step();
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_ready: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    tx_q = '{8'd5, 8'd200, 8'd17, 8'd99};
    model_seq();
    push_seq(0);
    observe(exp_q.size() + 5, -1);
    for (int k = 0; k < exp_q.size() + 5; k++) begin
      logic [8:0] e;
      e = exp_sample(k);
      vectors++;
      if ({samp_start[k], samp_a[k]} !== e || samp_rdy[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_burst k=%0d: start=%b inputA=%0d in_ready=%b, required start=%b inputA=%0d in_ready=0",
                 k, samp_start[k], samp_a[k], samp_rdy[k], e[8], e[7:0]);
      end
    end
    vectors++;
    if (bus.seq_len !== 5'd4 || bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_status: seq_len=%0d overflow=%b, required 4 0", bus.seq_len, bus.overflow);
    end
    // Producer offers a byte while the block is busy: must not be taken.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd77;
    bus.in_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (bus.in_ready !== 1'b0 || bus.start !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_wait k=%0d: in_ready=%b start=%b, required 0 0", k, bus.in_ready, bus.start);
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.done     = 1'b1;
    step();
    bus.done = 1'b0;
    for (int k = 0; k <= GAP; k++) begin
      vectors++;
      if (bus.in_ready !== (k >= GAP)) begin
        miscompares++;
        $display("FAIL basic_gap k=%0d: in_ready=%b, required %b", k, bus.in_ready, (k >= GAP));
      end
      if (k < GAP) step();
    end
  endtask

  task automatic test_single();
    tx_q = '{8'd42};
    model_seq();
    push_seq(0);
    observe(6, -1);
    for (int k = 0; k < 6; k++) begin
      logic [8:0] e;
      e = exp_sample(k);
      vectors++;
      if ({samp_start[k], samp_a[k]} !== e || samp_rdy[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL single_burst k=%0d: start=%b inputA=%0d in_ready=%b, required start=%b inputA=%0d in_ready=0",
                 k, samp_start[k], samp_a[k], samp_rdy[k], e[8], e[7:0]);
      end
    end
    vectors++;
    if (bus.seq_len !== 5'd1) begin
      miscompares++;
      $display("FAIL single_seq_len: seq_len=%0d, required 1", bus.seq_len);
    end
    finish_seq();
  endtask

  task automatic test_overflow();
    tx_q.delete();
    for (int i = 0; i < 20; i++) tx_q.push_back(8'(i));
    model_seq();
    push_seq(0);
    observe(exp_q.size() + 5, -1);
    for (int k = 0; k < exp_q.size() + 5; k++) begin
      logic [8:0] e;
      e = exp_sample(k);
      vectors++;
      if ({samp_start[k], samp_a[k]} !== e || samp_rdy[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL overflow_burst k=%0d: start=%b inputA=%0d in_ready=%b, required start=%b inputA=%0d in_ready=0",
                 k, samp_start[k], samp_a[k], samp_rdy[k], e[8], e[7:0]);
      end
    end
    vectors++;
    if (bus.seq_len !== 5'd16 || bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_status: seq_len=%0d overflow=%b, required 16 1", bus.seq_len, bus.overflow);
    end
    finish_seq();
  endtask

  task automatic test_gaps_done();
    tx_q.delete();
    for (int i = 0; i < 8; i++) tx_q.push_back(8'($urandom));
    model_seq();
    push_seq(40);
    // done on the final start cycle lands while still draining: ignored.
    observe(exp_q.size() + 6, exp_q.size());
    for (int k = 0; k < exp_q.size() + 6; k++) begin
      logic [8:0] e;
      e = exp_sample(k);
      vectors++;
      if ({samp_start[k], samp_a[k]} !== e || samp_rdy[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL gaps_burst k=%0d: start=%b inputA=%0d in_ready=%b, required start=%b inputA=%0d in_ready=0",
                 k, samp_start[k], samp_a[k], samp_rdy[k], e[8], e[7:0]);
      end
    end
    vectors++;
    if (bus.seq_len !== 5'd8 || bus.overflow !== exp_ovf) begin
      miscompares++;
      $display("FAIL gaps_status: seq_len=%0d overflow=%b, required 8 %b", bus.seq_len, bus.overflow, exp_ovf);
    end
    finish_seq();
  endtask

  task automatic test_random();
    int fixed_len[5] = '{1, 2, 15, 16, 17};
    for (int it = 0; it < 8; it++) begin
      int len;
      int done_at;
      len = (it < 5) ? fixed_len[it] : int'($urandom_range(1, 24));
      tx_q.delete();
      for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
      model_seq();
      push_seq(30);
      done_at = $urandom_range(0, exp_q.size());
      observe(exp_q.size() + 5, done_at);
      for (int k = 0; k < exp_q.size() + 5; k++) begin
        logic [8:0] e;
        e = exp_sample(k);
        vectors++;
        if ({samp_start[k], samp_a[k]} !== e || samp_rdy[k] !== 1'b0) begin
          miscompares++;
          $display("FAIL random_burst it=%0d len=%0d k=%0d: start=%b inputA=%0d in_ready=%b, required start=%b inputA=%0d in_ready=0",
                   it, len, k, samp_start[k], samp_a[k], samp_rdy[k], e[8], e[7:0]);
        end
      end
      vectors++;
      if (bus.seq_len !== 5'(exp_q.size()) || bus.overflow !== exp_ovf) begin
        miscompares++;
        $display("FAIL random_status it=%0d: seq_len=%0d overflow=%b, required %0d %b",
                 it, bus.seq_len, bus.overflow, exp_q.size(), exp_ovf);
      end
      finish_seq();
    end
  endtask

  task automatic test_reset_mid();
    tx_q = '{8'd11, 8'd22, 8'd33, 8'd44};
    model_seq();
    push_seq(0);
    step();
    step();
    vectors++;
    if (bus.start !== 1'b1 || bus.inputA !== 8'd22) begin
      miscompares++;
      $display("FAIL midreset_pre: start=%b inputA=%0d, required 1 22", bus.start, bus.inputA);
    end
    reset_n = 1'b0;
    exp_ovf = 1'b0;
    #1;
    vectors++;
    if (bus.start !== 1'b0 || bus.inputA !== 8'd0 || bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_async: start=%b inputA=%0d overflow=%b, required 0 0 0",
               bus.start, bus.inputA, bus.overflow);
    end
    step();
    step();
    reset_n = 1'b1;
    step();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.start !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_release: in_ready=%b start=%b, required 1 0", bus.in_ready, bus.start);
    end
    tx_q = '{8'd7, 8'd250, 8'd128};
    model_seq();
    push_seq(20);
    observe(exp_q.size() + 5, -1);
    for (int k = 0; k < exp_q.size() + 5; k++) begin
      logic [8:0] e;
      e = exp_sample(k);
      vectors++;
      if ({samp_start[k], samp_a[k]} !== e || samp_rdy[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_burst k=%0d: start=%b inputA=%0d in_ready=%b, required start=%b inputA=%0d in_ready=0",
                 k, samp_start[k], samp_a[k], samp_rdy[k], e[8], e[7:0]);
      end
    end
    vectors++;
    if (bus.seq_len !== 5'd3 || bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_status: seq_len=%0d overflow=%b, required 3 0", bus.seq_len, bus.overflow);
    end
    finish_seq();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    bus.done     = 1'b0;
    reset_n      = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_gaps_done();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
